mem_responder: RTL and testbench

Memory-side responder for the core's multicycle memory port. It accepts level-held read/write requests from the control/datapath, inserts a configurable number of wait states, and performs the access on an internal word-organised RAM. Byte lanes are aligned and loads sign- or zero-extended per funct3. `mem_complete` is pulsed exactly once per access, which is what the core's LOAD/STORE/PROLOGUE sequencing waits on.

---
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: level-held request, WAIT_STATES wait cycles, aligned/extended byte-lane access.
// Optional MEM_RESPONDER_MISALIGN_EN: misaligned halfword/word accesses fault instead of being forced aligned.
module mem_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned WAIT_STATES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [2:0]  mem_f3,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_complete,
   output logic        mem_fault
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] ram [DEPTH_WORDS];

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
      logic [31:0] s;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      s  = word >> {lane, 3'b000};
      sb = $signed(s[7:0]);
      sh = $signed(s[15:0]);
      case (f3)
         3'b000:  return 32'(sb);
         3'b001:  return 32'(sh);
         3'b100:  return {24'h0, s[7:0]};
         3'b101:  return {16'h0, s[15:0]};
         default: return s;
      endcase
   endfunction

   // In IDLE the access is described by the live request (needed when WAIT_STATES==0);
   // afterwards by the latched copy.
   logic [31:0]      acc_addr, acc_wdata;
   logic [2:0]       acc_f3;
   logic [1:0]       lane;
   logic             misalign, out_of_range, fault;
   logic [IDX_W-1:0] idx;
   logic [3:0]       be;
   logic [31:0]      st_word, load_val;

   assign acc_addr  = (state_q == IDLE) ? mem_addr  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;
   assign acc_f3    = (state_q == IDLE) ? mem_f3    : f3_q;
   assign idx       = acc_addr[IDX_W+1:2];

   always_comb begin
      lane     = acc_addr[1:0];
      misalign = 1'b0;
`ifdef MEM_RESPONDER_MISALIGN_EN
      misalign = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                 ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
      case (acc_f3[1:0])
         2'b01:   lane = {acc_addr[1], 1'b0};
         2'b10:   lane = 2'b00;
         default: lane = acc_addr[1:0];
      endcase
`endif
   end

   assign out_of_range = ({2'b00, acc_addr[31:2]} >= DEPTH_WORDS);
   assign fault        = out_of_range || (acc_f3[1:0] == 2'b11) || misalign;

   always_comb begin
      case (acc_f3[1:0])
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = 4'b0011 << lane;
         default: be = 4'b1111;
      endcase
   end

   assign st_word  = acc_wdata << {lane, 3'b000};
   assign load_val = load_extend(ram[idx], lane, acc_f3);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               f3_d    = mem_f3;
               wr_d    = mem_write;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = DONE;
                  if (!mem_write && !fault) rdata_d = load_val;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               if (!wr_q && !fault) rdata_d = load_val;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
   end

   // Commit on the edge that ends DONE; a reset on that edge drops the store.
   always_ff @(posedge clk) begin
      if (rst_n && (state_q == DONE) && wr_q && !fault) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram[idx][8*b +: 8] <= st_word[8*b +: 8];
         end
      end
   end

   assign mem_rdata    = rdata_q;
   assign mem_complete = (state_q == DONE);
   assign mem_fault    = (state_q == DONE) && fault;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: WAIT_STATES=1 instance driven from a vector table, WAIT_STATES=0 instance by hand.
// Expected completions go into per-instance queues; monitors pop them on every mem_complete pulse.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rd1, wr1, cmp1, flt1;
   logic [31:0] addr1, wd1, rdata1;
   logic [2:0]  f31;
   logic        rd0, wr0, cmp0, flt0;
   logic [31:0] addr0, wd0, rdata0;
   logic [2:0]  f30;

   mem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(1), .INIT_FILE("")) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1), .mem_addr(addr1),
      .mem_f3(f31), .mem_wdata(wd1), .mem_rdata(rdata1), .mem_complete(cmp1), .mem_fault(flt1));

   mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0), .mem_addr(addr0),
      .mem_f3(f30), .mem_wdata(wd0), .mem_rdata(rdata0), .mem_complete(cmp0), .mem_fault(flt0));

`ifdef MEM_RESPONDER_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   typedef struct { logic [31:0] rdata; logic fault; } exp_t;
   typedef struct { bit w; bit r; logic [31:0] a; logic [2:0] f; logic [31:0] wd; logic [31:0] rd; bit flt; } vec_t;

   exp_t        q1[$], q0[$];
   exp_t        e1, e0;
   vec_t        vt[$];
   logic [31:0] last_rd[2];
   int          cyc = 0;
   int          nvec = 0, nmis = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp1 === 1'b1) begin
         if (q1.size() == 0) begin
            nvec++; nmis++;
            $display("FAIL dut1_unexpected_pulse: got pulse at cycle %0d expected none", cyc);
         end else begin
            e1 = q1.pop_front();
            check("dut1_rdata", rdata1, e1.rdata);
            check("dut1_fault", {31'h0, flt1}, {31'h0, e1.fault});
         end
      end
   end

   always @(negedge clk) begin
      if (cmp0 === 1'b1) begin
         if (q0.size() == 0) begin
            nvec++; nmis++;
            $display("FAIL dut0_unexpected_pulse: got pulse at cycle %0d expected none", cyc);
         end else begin
            e0 = q0.pop_front();
            check("dut0_rdata", rdata0, e0.rdata);
            check("dut0_fault", {31'h0, flt0}, {31'h0, e0.fault});
         end
      end
   end

   // One access with the request held through the completion edge and dropped in the following IDLE cycle.
   task automatic access(input bit d, input bit w, input bit r, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_f, input int exp_lat);
      exp_t e;
      int   t0;
      bit   got;
      @(negedge clk);
      e.fault = exp_f;
      if (w || exp_f) e.rdata = last_rd[d];
      else begin
         e.rdata    = exp_rd;
         last_rd[d] = exp_rd;
      end
      if (d) begin
         wr1 = w; rd1 = r; addr1 = a; f31 = f; wd1 = wd; q1.push_back(e);
      end else begin
         wr0 = w; rd0 = r; addr0 = a; f30 = f; wd0 = wd; q0.push_back(e);
      end
      t0  = cyc;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ((d ? cmp1 : cmp0) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (got) check("latency", 32'(cyc - t0), 32'(exp_lat));
      else begin
         nvec++; nmis++;
         $display("FAIL latency_timeout: got no completion for addr %h expected one within 20 cycles", a);
      end
      @(negedge clk);
      check("no_double_pulse", {31'h0, (d ? cmp1 : cmp0)}, 32'h0);
      if (d) begin wr1 = 1'b0; rd1 = 1'b0; end
      else   begin wr0 = 1'b0; rd0 = 1'b0; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      {rd1, wr1, addr1, f31, wd1} = '0;
      {rd0, wr0, addr0, f30, wd0} = '0;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;

      vt.push_back('{1'b1, 1'b0, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h11, 3'b000, 32'hFFFFFF5A, 32'h0,        1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h11, 3'b000, 32'h0,        32'h0000005A, 1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h12, 3'b001, 32'h0,        32'hFFFFDEAD, 1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h12, 3'b101, 32'h0,        32'h0000DEAD, 1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h14, 3'b010, 32'h11223344, 32'h0,        1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h14, 3'b001, 32'hABCD8001, 32'h0,        1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h15, 3'b001, 32'h0,        32'hFFFF8001, MIS});
      vt.push_back('{1'b0, 1'b1, 32'h17, 3'b010, 32'h0,        32'h11228001, MIS});
      vt.push_back('{1'b0, 1'b1, 32'h15, 3'b100, 32'h0,        32'h00000080, 1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h00, 3'b010, 32'h01020304, 32'h0,        1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h4000, 3'b010, 32'h0,      32'h0,        1'b1});
      vt.push_back('{1'b1, 1'b0, 32'h4000, 3'b010, 32'hCAFEF00D, 32'h0,      1'b1});
      vt.push_back('{1'b0, 1'b1, 32'h00, 3'b010, 32'h0,        32'h01020304, 1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h10, 3'b111, 32'h0,        32'h0,        1'b1});
      vt.push_back('{1'b0, 1'b1, 32'h10, 3'b011, 32'h0,        32'h0,        1'b1});
      vt.push_back('{1'b0, 1'b1, 32'h10, 3'b010, 32'h0,        32'hDEAD5AEF, 1'b0});
      vt.push_back('{1'b1, 1'b1, 32'h18, 3'b010, 32'h55667788, 32'h0,        1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h18, 3'b010, 32'h0,        32'h55667788, 1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h1B, 3'b001, 32'h0000BEEF, 32'h0,        MIS});
      vt.push_back('{1'b0, 1'b1, 32'h18, 3'b010, 32'h0,        (MIS ? 32'h55667788 : 32'hBEEF7788), 1'b0});
      vt.push_back('{1'b0, 1'b1, 32'h80000010, 3'b010, 32'h0,  32'h0,        1'b1});
      vt.push_back('{1'b1, 1'b0, 32'h20, 3'b010, 32'hA5A5A5A5, 32'h0,        1'b0});

      repeat (3) @(negedge clk);
      check("reset_rdata1", rdata1, 32'h0);
      check("reset_complete1", {31'h0, cmp1}, 32'h0);
      check("reset_fault1", {31'h0, flt1}, 32'h0);
      check("reset_rdata0", rdata0, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++)
         access(1'b1, vt[i].w, vt[i].r, vt[i].a, vt[i].f, vt[i].wd, vt[i].rd, vt[i].flt, 2);

      // Reset during WAIT of a store: no pulse, no commit, rdata back to 0.
      @(negedge clk);
      wr1 = 1'b1; addr1 = 32'h20; f31 = 3'b010; wd1 = 32'h12345678;
      @(negedge clk);
      check("abort_in_wait_state", {31'h0, cmp1}, 32'h0);
      rst_n = 1'b0;
      wr1   = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_no_pulse", {31'h0, cmp1}, 32'h0);
      rst_n = 1'b1;
      check("abort_rdata_reset", rdata1, 32'h0);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      access(1'b1, 1'b0, 1'b1, 32'h20, 3'b010, 32'h0, 32'hA5A5A5A5, 1'b0, 2);

      // Zero wait states: stores, then back-to-back fetches with the request held.
      access(1'b0, 1'b1, 1'b0, 32'h0, 3'b010, 32'h13579BDF, 32'h0, 1'b0, 1);
      access(1'b0, 1'b1, 1'b0, 32'h4, 3'b010, 32'h2468ACE0, 32'h0, 1'b0, 1);
      @(negedge clk);
      rd0 = 1'b1; addr0 = 32'h0; f30 = 3'b010;
      e0.fault = 1'b0;
      q0.push_back('{32'h13579BDF, 1'b0});
      q0.push_back('{32'h2468ACE0, 1'b0});
      last_rd[0] = 32'h2468ACE0;
      @(negedge clk);
      check("fetch0_complete", {31'h0, cmp0}, 32'h1);
      addr0 = 32'h4;
      @(negedge clk);
      check("fetch_gap_idle", {31'h0, cmp0}, 32'h0);
      @(negedge clk);
      check("fetch1_complete", {31'h0, cmp0}, 32'h1);
      @(negedge clk);
      rd0 = 1'b0;
      access(1'b0, 1'b0, 1'b1, 32'h100, 3'b010, 32'h0, 32'h0, 1'b1, 1);
      access(1'b0, 1'b1, 1'b0, 32'h100, 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
      access(1'b0, 1'b0, 1'b1, 32'h0, 3'b010, 32'h0, 32'h13579BDF, 1'b0, 1);

      repeat (3) @(negedge clk);
      check("dut1_queue_drained", 32'(q1.size()), 32'h0);
      check("dut0_queue_drained", 32'(q0.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
